// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is combinational; updates and flushes take effect at the next rising edge.
module branch_target_buffer #(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 30,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_en,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              flush_all,
    output logic [CNT_W-1:0]  mispredict_cnt
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);

    logic              valid_q [ENTRIES];
    logic [TAG_W-1:0]  tag_q   [ENTRIES];
    logic [ADDR_W-1:0] tgt_q   [ENTRIES];
    logic [CTR_W-1:0]  ctr_q   [ENTRIES];
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [IDX_W-1:0]  l_idx, u_idx;
    logic [TAG_W-1:0]  l_tag, u_tag;
    logic              u_hit, u_pred, mispred, wr_en;
    logic [CTR_W-1:0]  ctr_d;
    logic [ADDR_W-1:0] tgt_d;

    assign l_idx = lookup_pc[IDX_W-1:0];
    assign l_tag = lookup_pc[ADDR_W-1:IDX_W];
    assign u_idx = upd_pc[IDX_W-1:0];
    assign u_tag = upd_pc[ADDR_W-1:IDX_W];

    always_comb begin
        pred_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag) && ctr_q[l_idx][CTR_W-1];
        pred_target = pred_hit ? tgt_q[l_idx] : '0;
    end

    // Mispredict is judged on pre-update state and still counts when a flush wins.
    always_comb begin
        u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        u_pred  = u_hit && ctr_q[u_idx][CTR_W-1];
        mispred = upd_en && ((u_pred != upd_taken) ||
                             (upd_taken && u_pred && (tgt_q[u_idx] != upd_target)));
        cnt_d   = cnt_q;
        if (mispred && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_comb begin
        wr_en = upd_en && !flush_all && (u_hit || upd_taken);
        tgt_d = upd_taken ? upd_target : tgt_q[u_idx];
        ctr_d = CTR_INIT;
        if (u_hit) begin
            if (upd_taken)
                ctr_d = (ctr_q[u_idx] == CTR_MAX) ? CTR_MAX : ctr_q[u_idx] + CTR_W'(1);
            else
                ctr_d = (ctr_q[u_idx] == '0) ? '0 : ctr_q[u_idx] - CTR_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= '0;
            end
            cnt_q <= '0;
        end else begin
            if (flush_all) begin
                for (int i = 0; i < ENTRIES; i++)
                    valid_q[i] <= 1'b0;
            end else if (wr_en) begin
                valid_q[u_idx] <= 1'b1;
                tag_q[u_idx]   <= u_tag;
                tgt_q[u_idx]   <= tgt_d;
                ctr_q[u_idx]   <= ctr_d;
            end
            cnt_q <= cnt_d;
        end
    end

    assign mispredict_cnt = cnt_q;
endmodule

// File: tb/tb_branch_target_buffer.sv
// Randomized bench for branch_target_buffer against an arithmetic reference model.
// Runs with ENTRIES=16, CTR_W=2 and a 4-bit mispredict counter so saturation is reachable.
module tb_branch_target_buffer;
    localparam int ENTRIES = 16;
    localparam int ADDR_W  = 30;
    localparam int CTR_W   = 2;
    localparam int CNT_W   = 4;
    localparam int CMAX    = (1 << CTR_W) - 1;
    localparam int CNTMAX  = (1 << CNT_W) - 1;

    logic              CLK, nRST;
    logic [ADDR_W-1:0] lookup_pc, upd_pc, upd_target, pred_target;
    logic              pred_hit, upd_en, upd_taken, flush_all;
    logic [CNT_W-1:0]  mispredict_cnt;

    branch_target_buffer #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .CTR_W(CTR_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc), .pred_hit(pred_hit),
        .pred_target(pred_target), .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .flush_all(flush_all), .mispredict_cnt(mispredict_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk = 0, n_fail = 0;

    // Reference state: entry i holds branch pc with pc % ENTRIES == i.
    bit              m_v   [ENTRIES];
    longint          m_tag [ENTRIES];
    longint          m_tgt [ENTRIES];
    int              m_ctr [ENTRIES];
    int              m_cnt;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_pred(input longint pc);
        int i = int'(pc % ENTRIES);
        return m_v[i] && (m_tag[i] == pc / ENTRIES) && (m_ctr[i] >= (CMAX + 1) / 2);
    endfunction

    function automatic longint m_ptgt(input longint pc);
        return m_pred(pc) ? m_tgt[int'(pc % ENTRIES)] : 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
        end
        m_cnt = 0;
    endtask

    task automatic m_update(input bit en, input longint pc, input bit tk, input longint tg, input bit fl);
        int  i   = int'(pc % ENTRIES);
        bit  hit = m_v[i] && (m_tag[i] == pc / ENTRIES);
        bit  p   = m_pred(pc);
        if (en && ((p != tk) || (tk && p && m_tgt[i] != tg)) && m_cnt < CNTMAX)
            m_cnt++;
        if (fl) begin
            for (int k = 0; k < ENTRIES; k++) m_v[k] = 0;
        end else if (en) begin
            if (hit) begin
                if (tk) begin
                    m_ctr[i] = (m_ctr[i] < CMAX) ? m_ctr[i] + 1 : CMAX;
                    m_tgt[i] = tg;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (tk) begin
                m_v[i] = 1; m_tag[i] = pc / ENTRIES; m_tgt[i] = tg; m_ctr[i] = (CMAX + 1) / 2;
            end
        end
    endtask

    // Drive one cycle: check the lookup against pre-edge state, then advance the model.
    task automatic cyc(input bit en, input longint pc, input bit tk, input longint tg,
                       input bit fl, input longint lpc);
        upd_en = en; upd_pc = ADDR_W'(pc); upd_taken = tk; upd_target = ADDR_W'(tg);
        flush_all = fl; lookup_pc = ADDR_W'(lpc);
        @(negedge CLK);
        chk("hit", pred_hit, m_pred(lpc));
        chk("target", pred_target, m_ptgt(lpc));
        chk("mispredict_cnt", mispredict_cnt, m_cnt);
        @(posedge CLK);
        m_update(en, pc, tk, tg, fl);
        #1;
    endtask

    initial begin
        m_reset();
        nRST = 1'b0; upd_en = 0; upd_pc = '0; upd_taken = 0; upd_target = '0;
        flush_all = 0; lookup_pc = ADDR_W'(32'h40);
        #7;
        chk("rst_hit", pred_hit, 0);
        chk("rst_target", pred_target, 0);
        chk("rst_cnt", mispredict_cnt, 0);
        @(negedge CLK) nRST = 1'b1;
        @(posedge CLK); #1;

        // First allocation, then decay through three not-taken updates.
        cyc(1, 'h40, 1, 'h80, 0, 'h40);
        cyc(0, 0, 0, 0, 0, 'h40);
        chk("alloc_hit", pred_hit, 1);
        chk("alloc_target", pred_target, 'h80);
        repeat (3) cyc(1, 'h40, 0, 0, 0, 'h40);
        cyc(0, 0, 0, 0, 0, 'h40);
        chk("decay_cnt", mispredict_cnt, 2);

        // Aliasing entries at index 0 with tags 4 and 5.
        cyc(1, 'h40, 1, 'h100, 0, 'h40);
        cyc(1, 'h50, 1, 'h200, 0, 'h50);
        cyc(0, 0, 0, 0, 0, 'h40);
        cyc(0, 0, 0, 0, 0, 'h50);
        chk("alias_target", pred_target, 'h200);

        // Flush wins over a simultaneous update but the mispredict still counts.
        cyc(1, 'h60, 1, 'h300, 1, 'h60);
        cyc(0, 0, 0, 0, 0, 'h50);
        cyc(0, 0, 0, 0, 0, 'h60);

        // Alternating directions on one branch mispredict every time until saturation.
        for (int k = 0; k < 20; k++) cyc(1, 'h70, (k % 2) == 0, 'h10, 0, 'h70);
        cyc(0, 0, 0, 0, 0, 'h70);
        chk("cnt_saturated", mispredict_cnt, CNTMAX);

        // Random traffic over a small pc pool to force aliasing and target changes.
        for (int k = 0; k < 600; k++) begin
            longint pc  = $urandom_range(0, 47);
            longint lpc = ($urandom_range(0, 3) == 0) ? pc : longint'($urandom_range(0, 47));
            cyc($urandom_range(0, 3) != 0, pc, $urandom_range(0, 1), $urandom_range(0, 3),
                $urandom_range(0, 40) == 0, lpc);
        end

        // Reset mid-operation drops the pending update.
        cyc(1, 'h23, 1, 'h55, 0, 'h23);
        upd_en = 1; upd_pc = ADDR_W'(32'h24); upd_taken = 1; upd_target = ADDR_W'(32'h66);
        lookup_pc = ADDR_W'(32'h23);
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        chk("midrst_hit", pred_hit, 0);
        chk("midrst_target", pred_target, 0);
        chk("midrst_cnt", mispredict_cnt, 0);
        @(posedge CLK); #1;
        upd_en = 0;
        m_reset();
        @(negedge CLK) nRST = 1'b1;
        @(posedge CLK); #1;
        cyc(0, 0, 0, 0, 0, 'h24);
        cyc(0, 0, 0, 0, 0, 'h23);
        for (int k = 0; k < 100; k++) begin
            longint pc = $urandom_range(0, 47);
            cyc($urandom_range(0, 1), pc, $urandom_range(0, 1), $urandom_range(0, 3), 0, pc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
